// File: rtl/mult_pkg.sv
// Shared types and constants for the 8x8 signed add-shift multiplier.
package mult_pkg;

    localparam int WIDTH  = 8;
    localparam int N_ITER = WIDTH;

    localparam logic FN_ADD = 1'b0;
    localparam logic FN_SUB = 1'b1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ADD   = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } ctrl_state_t;

endpackage

// File: rtl/xab_shift_reg.sv
// X:A:B product register; X is the sign of A and is replicated on shift.
module xab_shift_reg
    import mult_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_b,
    input  logic             clear_xa,
    input  logic             load_xa,
    input  logic             shift,
    input  logic [WIDTH-1:0] switches,
    input  logic [WIDTH-1:0] sum,
    input  logic             co,
    output logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] b,
    output logic             x
);

    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             x_q, x_d;

    always_comb begin
        a_d = a_q;
        b_d = b_q;
        x_d = x_q;
        if (clear_xa) begin
            a_d = '0;
            x_d = 1'b0;
        end
        if (load_b) begin
            b_d = switches;
        end
        if (load_xa) begin
            a_d = sum;
            x_d = co;
        end
        if (shift) begin
            {a_d, b_d} = {x_q, a_q, b_q[WIDTH-1:1]};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_q <= '0;
            b_q <= '0;
            x_q <= 1'b0;
        end else begin
            a_q <= a_d;
            b_q <= b_d;
            x_q <= x_d;
        end
    end

    assign a = a_q;
    assign b = b_q;
    assign x = x_q;

endmodule

// File: rtl/mult_ctrl_8x8.sv
// Control FSM, S register and iteration counter for the signed add-shift multiplier.
module mult_ctrl_8x8
    import mult_pkg::*;
(
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Run,
    input  logic             ClearA_LoadB,
    input  logic [WIDTH-1:0] Switches,
    output logic [WIDTH-1:0] adder_a,
    output logic [WIDTH-1:0] adder_s,
    output logic             adder_fn,
    input  logic [WIDTH-1:0] adder_sum,
    input  logic             adder_co,
    output logic [WIDTH-1:0] Aval,
    output logic [WIDTH-1:0] Bval,
    output logic             Xval,
    output logic             Done
);

    localparam int CNT_W = $clog2(N_ITER);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(N_ITER - 1);

    ctrl_state_t      state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [WIDTH-1:0] s_q, s_d;

    logic load_b, clear_xa, load_xa, shift;
    logic last_iter;

    assign last_iter = (count_q == LAST);

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        s_d      = s_q;
        load_b   = 1'b0;
        clear_xa = 1'b0;
        load_xa  = 1'b0;
        shift    = 1'b0;
        adder_fn = FN_ADD;
        Done     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (Run) begin
                    s_d      = Switches;
                    clear_xa = 1'b1;
                    count_d  = '0;
                    state_d  = ADD;
                end else if (ClearA_LoadB) begin
                    clear_xa = 1'b1;
                    load_b   = 1'b1;
                end
            end
            ADD: begin
                // The final partial product carries negative weight.
                adder_fn = last_iter ? FN_SUB : FN_ADD;
                load_xa  = Bval[0];
                state_d  = SHIFT;
            end
            SHIFT: begin
                shift = 1'b1;
                if (last_iter) begin
                    state_d = DONE;
                end else begin
                    count_d = count_q + CNT_W'(1);
                    state_d = ADD;
                end
            end
            DONE: begin
                Done = 1'b1;
                if (!Run) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state_q <= IDLE;
            count_q <= '0;
            s_q     <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            s_q     <= s_d;
        end
    end

    xab_shift_reg u_xab (
        .clk      (Clk),
        .rst_n    (Reset),
        .load_b   (load_b),
        .clear_xa (clear_xa),
        .load_xa  (load_xa),
        .shift    (shift),
        .switches (Switches),
        .sum      (adder_sum),
        .co       (adder_co),
        .a        (Aval),
        .b        (Bval),
        .x        (Xval)
    );

    assign adder_a = Aval;
    assign adder_s = s_q;

endmodule

// File: tb/tb_mult_ctrl_8x8.sv
// Testbench for mult_ctrl_8x8 with a behavioural 9-bit adder beside the DUT.
module tb_mult_ctrl_8x8;

    logic       Clk;
    logic       Reset;
    logic       Run;
    logic       ClearA_LoadB;
    logic [7:0] Switches;
    logic [7:0] adder_a;
    logic [7:0] adder_s;
    logic       adder_fn;
    logic [7:0] adder_sum;
    logic       adder_co;
    logic [7:0] Aval;
    logic [7:0] Bval;
    logic       Xval;
    logic       Done;

    int checks;
    int failures;

    mult_ctrl_8x8 dut (
        .Clk          (Clk),
        .Reset        (Reset),
        .Run          (Run),
        .ClearA_LoadB (ClearA_LoadB),
        .Switches     (Switches),
        .adder_a      (adder_a),
        .adder_s      (adder_s),
        .adder_fn     (adder_fn),
        .adder_sum    (adder_sum),
        .adder_co     (adder_co),
        .Aval         (Aval),
        .Bval         (Bval),
        .Xval         (Xval),
        .Done         (Done)
    );

    logic [8:0] add_r;
    always_comb begin
        add_r = '0;
        if (adder_fn) add_r = {adder_a[7], adder_a} - {adder_s[7], adder_s};
        else          add_r = {adder_a[7], adder_a} + {adder_s[7], adder_s};
    end
    assign adder_sum = add_r[7:0];
    assign adder_co  = add_r[8];

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    typedef struct {
        logic       ld;
        logic [7:0] b;
        logic [7:0] s;
        logic [7:0] ea;
        logic [7:0] eb;
        logic       ex;
    } vec_t;

    vec_t tbl [6];

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Signed product as plain integer arithmetic: {X, A, B}.
    function automatic logic [16:0] ref_prod(input logic [7:0] b,
                                             input logic [7:0] s);
        int bi, si, p;
        logic [15:0] p16;
        bi  = int'($signed(b));
        si  = int'($signed(s));
        p   = bi * si;
        p16 = p[15:0];
        return {p16[15], p16};
    endfunction

    task automatic load_b(input logic [7:0] v);
        Switches     = v;
        ClearA_LoadB = 1'b1;
        tick();
        ClearA_LoadB = 1'b0;
        check("load_b", {23'd0, Xval, Aval, Bval}, {23'd0, 1'b0, 8'h00, v});
    endtask

    task automatic run_mult(input string name, input logic [7:0] s,
                            input logic [7:0] ea, input logic [7:0] eb,
                            input logic ex, input bit hold);
        logic [15:0] fnv;
        int          done_at;
        bit          stay_bad;
        fnv      = '0;
        done_at  = 0;
        stay_bad = 0;
        Switches = s;
        Run      = 1'b1;
        for (int i = 1; i <= 30 && done_at == 0; i++) begin
            tick();
            if (i == 1) begin
                Switches     = ~s;
                ClearA_LoadB = 1'b1;
            end
            if (i <= 16) fnv[i-1] = adder_fn;
            if (Done) done_at = i;
        end
        ClearA_LoadB = 1'b0;
        check({name, "_latency"}, done_at, 17);
        check({name, "_fn"}, {16'd0, fnv}, 32'h0000_4000);
        check({name, "_xab"}, {15'd0, Xval, Aval, Bval}, {15'd0, ex, ea, eb});
        if (hold) begin
            for (int j = done_at + 1; j <= 40; j++) begin
                tick();
                if (!Done || Aval !== ea || Bval !== eb || Xval !== ex)
                    stay_bad = 1;
            end
            check({name, "_hold"}, {31'd0, stay_bad}, 32'd0);
        end
        Run = 1'b0;
        tick();
        check({name, "_idle"}, {31'd0, Done}, 32'd0);
    endtask

    initial begin
        logic [7:0]  rb, rs;
        logic [16:0] e;
        checks       = 0;
        failures     = 0;
        Reset        = 1'b0;
        Run          = 1'b0;
        ClearA_LoadB = 1'b0;
        Switches     = 8'h00;

        tbl[0] = '{1'b1, 8'h3B, 8'h07, 8'h01, 8'h9D, 1'b0};
        tbl[1] = '{1'b0, 8'h00, 8'h02, 8'hFF, 8'h3A, 1'b1};
        tbl[2] = '{1'b1, 8'h3B, 8'hF9, 8'hFE, 8'h63, 1'b1};
        tbl[3] = '{1'b1, 8'h80, 8'h80, 8'h40, 8'h00, 1'b0};
        tbl[4] = '{1'b1, 8'h00, 8'h55, 8'h00, 8'h00, 1'b0};
        tbl[5] = '{1'b1, 8'h80, 8'h7F, 8'hC0, 8'h80, 1'b1};

        tick();
        tick();
        check("reset_xab", {15'd0, Xval, Aval, Bval}, 32'd0);
        check("reset_done_s", {23'd0, Done, adder_s}, 32'd0);
        Reset = 1'b1;
        tick();
        check("idle_hold", {15'd0, Done, Aval, Bval}, 32'd0);

        for (int k = 0; k < 6; k++) begin
            if (tbl[k].ld) load_b(tbl[k].b);
            run_mult($sformatf("vec%0d", k), tbl[k].s,
                     tbl[k].ea, tbl[k].eb, tbl[k].ex, 1'b0);
        end

        load_b(8'h3B);
        run_mult("held_run", 8'h07, 8'h01, 8'h9D, 1'b0, 1'b1);

        load_b(8'h5A);
        Switches = 8'h33;
        Run      = 1'b1;
        for (int i = 0; i < 6; i++) tick();
        Reset = 1'b0;
        tick();
        check("midop_reset", {14'd0, Done, Xval, Aval, Bval}, 32'd0);
        check("midop_reset_s", {23'd0, adder_fn, adder_s}, 32'd0);
        Run   = 1'b0;
        Reset = 1'b1;
        tick();
        check("post_reset_idle", {31'd0, Done}, 32'd0);
        e = ref_prod(8'h5A, 8'h33);
        load_b(8'h5A);
        run_mult("fresh", 8'h33, e[15:8], e[7:0], e[16], 1'b0);

        for (int k = 0; k < 20; k++) begin
            rs = 8'($urandom);
            if (k % 4 == 3) begin
                rb = Bval;
            end else begin
                rb = 8'($urandom);
                load_b(rb);
            end
            e = ref_prod(rb, rs);
            run_mult($sformatf("rand%0d", k), rs, e[15:8], e[7:0], e[16], 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mult_ctrl_8x8.md
Name: mult_ctrl_8x8

Overview:
Control FSM and X:A:B register file for the 8x8 signed add-shift multiplier.
It drives the 9-bit add/subtract unit with A and the multiplicand S, and consumes that unit's 8-bit sum and 9th (sign) bit.
It accumulates the 16-bit two's-complement product in A:B over 8 add/shift iterations.
It sits between the board switch/button inputs and the hex displays in the lab top level.

Parameters:
WIDTH, 8, operand width; A, B and S are WIDTH bits; product is 2*WIDTH.
N_ITER, WIDTH, add/shift iterations; the last one uses subtract.

Ports:
Clk  in  1  system clock; all state changes on rising edge.
Reset  in  1  synchronous, active-low reset.
Run  in  1  start request, level-sensitive, already debounced/synchronized.
ClearA_LoadB  in  1  in IDLE: A<=0, X<=0, B<=Switches.
Switches  in  WIDTH  operand input; loaded into B (ClearA_LoadB) or S (Run).
adder_a  out  WIDTH  operand A to the adder (= A register).
adder_s  out  WIDTH  operand S to the adder (= S register).
adder_fn  out  1  adder function select: 0 = A+S, 1 = A-S.
adder_sum  in  WIDTH  adder result bits [7:0].
adder_co  in  1  adder result bit 8 (sign extension of the 9-bit result).
Aval  out  WIDTH  A register (product high byte).
Bval  out  WIDTH  B register (product low byte).
Xval  out  1  X register (sign of A).
Done  out  1  high while in DONE state.

Behaviour:
- Reset (Reset==0 at a rising edge) overrides everything, including mid-operation:
  - A=0, B=0, S=0, X=0, count=0, state=IDLE, Done=0.
- FSM states:
  - IDLE -> ADD on Run==1. On that edge: S<=Switches, A<=0, X<=0, count<=0; B is kept, so chained multiplies are allowed.
  - In IDLE with Run==0 and ClearA_LoadB==1: A<=0, X<=0, B<=Switches. Run has priority over ClearA_LoadB.
  - ADD (1 cycle): if B[0]==1, A<=adder_sum and X<=adder_co; else A and X hold. Next state is SHIFT.
  - SHIFT (1 cycle): {X,A,B} <= {X, X, A, B[WIDTH-1:1]}, an arithmetic right shift with X replicated.
    - count<=count+1.
    - Next state is DONE if count==N_ITER-1, else ADD.
  - DONE: Done=1 and registers hold. DONE -> IDLE when Run==0. A held-high Run must not restart.
- adder_fn is 1 only in ADD with count==N_ITER-1; otherwise it is 0.
- Adder path is combinational: adder_sum/adder_co are valid in the same cycle as adder_a/adder_s/adder_fn.
- Latency: Run sampled at edge t; first ADD in cycle t+1; DONE entered at edge t+2*N_ITER+1 (t+17 for WIDTH=8).
- Result: {A,B} is the signed product of the B value at start and S. X equals A[WIDTH-1] after completion.
- ClearA_LoadB and Switches changes are ignored outside IDLE.
- count is 3 bits for WIDTH=8 ($clog2(N_ITER)). It never wraps inside an operation and is cleared on start.
- -128 * -128 must give +16384 with no overflow. The 9-bit adder sign bit keeps the last subtract exact.

Decomposition:
- Package mult_pkg holds:
  - state enum ctrl_state_t {IDLE, ADD, SHIFT, DONE};
  - localparams WIDTH=8 and N_ITER=8;
  - FN_ADD=1'b0 and FN_SUB=1'b1.
- One sub-module, xab_shift_reg: the X:A:B register with load_b, clear_xa, load_xa (from adder) and shift enables.
- The FSM and counter stay in mult_ctrl_8x8. The adder is instantiated beside this block in the parent, not inside it.

Test Plan:
- Reset=0 for 2 cycles, then 1 -> A=0, B=0, X=0, Done=0, state IDLE.
- ClearA_LoadB with Switches=0x3B; Run with Switches=0x07 -> Done after 17 cycles; A=0x01, B=0x9D, X=0 (413).
- B=0x3B, S=0xF9 (-7) -> A=0xFE, B=0x63, X=1 (-413). Check adder_fn=1 only in the 8th ADD cycle.
- B=0x80, S=0x80 -> A=0x40, B=0x00, X=0 (+16384). B=0x00, S=0x55 -> A=0x00, B=0x00.
- Chained operation after 0x01:0x9D, release Run, then Run with Switches=0x02 -> B treated as -99; A=0xFF, B=0x3A, X=1 (-198).
- Run held 40 cycles -> exactly one multiply, Done stays 1.
- Reset=0 at cycle 6 of an operation -> next edge all zero, IDLE. Run then completes a fresh multiply correctly.
